load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Data-memory access stage of the RV32I single-cycle core. It sits downstream of the register file and ALU, and upstream of the writeback mux. It takes the effective address, rs2 data and funct3 for a load or store, and runs a request/grant/response transaction on the data-memory bus. It returns sign- or zero-extended load data and raises `stall` to freeze the PC while an access is in flight.

Parameters:
TIMEOUT_CYCLES, 16, maximum cycles spent in REQ+WAIT before the access is aborted with an error.
CNT_W, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter (derived; do not override).

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
ls_valid  input  1  memory instruction present; held by core until ls_done
ls_we  input  1  1 = store, 0 = load
funct3  input  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
addr  input  32  effective byte address from ALU
store_data  input  32  rs2 value
stall  output  1  ls_valid & ~ls_done; freezes PC
ls_done  output  1  one-cycle completion pulse
ls_err  output  1  pulses with ls_done on misaligned, illegal funct3 or timeout
load_data  output  32  extended load result; held until the next load completes
mem_req  output  1  bus request
mem_gnt  input  1  bus accepts request (address/write phase)
mem_addr  output  32  word-aligned address {addr[31:2],2'b00}
mem_we  output  1  write enable
mem_be  output  4  byte enables
mem_wdata  output  32  lane-replicated store data
mem_rvalid  input  1  read data valid, earliest one cycle after gnt
mem_rdata  input  32  read word

Behaviour:
- Reset: clk/reset are asynchronous, active-high. State goes to IDLE; every registered output (ls_done, ls_err, load_data, mem_req, mem_addr, mem_we, mem_be, mem_wdata) resets to 0 and the counter clears. Reset mid-transaction drops mem_req immediately. A late mem_rvalid after reset is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, ls_valid=1: decode the request.
  - Error conditions: illegal funct3 (loads 011/110/111; stores anything but 000/001/010), halfword with addr[0]=1, or word with addr[1:0]!=0.
  - On error: go to DONE with ls_err pending and load_data <= 0. No bus activity.
  - Otherwise: latch mem_addr, mem_we, mem_be, mem_wdata, funct3 and addr[1:0]; clear the counter; go to REQ.
- Byte enables: B = 4'b0001<<addr[1:0]; H = 4'b0011<<addr[1:0]; W = 4'b1111.
- Store data: mem_wdata = {4{sd[7:0]}} for SB, {2{sd[15:0]}} for SH, sd for SW.
- REQ: mem_req=1; address, data, we and be are held stable.
  - mem_gnt=1 on a store: go to DONE (stores complete on grant).
  - mem_gnt=1 on a load: go to WAIT.
  - mem_req deasserts on the cycle after the grant.
- WAIT: on mem_rvalid, shift the word: r = mem_rdata >> (8*addr[1:0]).
  - LB sign-extends r[7:0]; LBU zero-extends r[7:0]; LH/LHU sign-/zero-extend r[15:0]; LW takes the full word.
  - Write the result to load_data and go to DONE.
- Timeout: the counter increments in every REQ/WAIT cycle without progress. If the counter == TIMEOUT_CYCLES-1 with no gnt (REQ) or no rvalid (WAIT), go to DONE with ls_err and load_data <= 0. The transaction is abandoned and mem_req drops. If the progress event and expiry happen in the same cycle, the progress event wins.
- DONE: ls_done=1, plus ls_err if flagged, for exactly one cycle, then return to IDLE.
  - A ls_valid still high in the following cycle is treated as the next instruction and accepted.
  - mem_rvalid outside WAIT is ignored.
- Latency from the accept cycle (cycle 0):
  - Error: ls_done at cycle 1.
  - Store with grant in cycle 1: ls_done at cycle 2.
  - Load with grant in cycle 1 and rvalid in cycle 2: ls_done at cycle 3.
  - Timeout with no grant (TIMEOUT_CYCLES=16): ls_done/ls_err at cycle 17.
- Stores never modify load_data.

Test Plan:
- Load extension: mem_rdata=0x80FF7F01.
  - LB addr=0x103 -> load_data 0xFFFFFF80.
  - LBU addr=0x102 -> 0x000000FF.
  - LH addr=0x102 -> 0xFFFF80FF.
  - LW addr=0x100 -> 0x80FF7F01.
  - Each ls_done arrives 3 cycles after accept; mem_addr=0x100.
- Stores:
  - SB addr=0x205, sd=0x123456AB -> mem_be=0010, mem_wdata=0xABABABAB, mem_we=1.
  - SH addr=0x206 -> mem_be=1100, mem_wdata=0x56AB56AB.
  - ls_done 2 cycles after accept; load_data unchanged.
- Misaligned/illegal:
  - LW addr=0x102, SH addr=0x301, and load funct3=011 each give ls_done+ls_err at cycle 1.
  - mem_req never rises; load_data=0.
- Backpressure: mem_gnt withheld 5 cycles, then rvalid 3 cycles later.
  - mem_req and its fields stay stable throughout; stall stays high.
  - ls_done at cycle 10 with correct data and no error.
- Timeout:
  - No gnt for 16 cycles -> ls_done+ls_err at cycle 17, mem_req low afterwards.
  - Repeat with rvalid arriving on the expiry cycle in WAIT -> data accepted, no error.
- Reset mid-load: assert reset while in WAIT -> mem_req/ls_done/load_data 0 immediately. A subsequent stray mem_rvalid is ignored. A new LW after reset completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I data-memory access stage (request/grant/response bus, load extension, timeout)
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   ls_valid, ls_we       memory instruction present (held until ls_done); 1 = store
//   funct3, addr          access size/sign and effective byte address
//   store_data            rs2 value for stores
//   stall                 freezes the PC while an access is outstanding
//   ls_done, ls_err       one-cycle completion pulse, with error flag
//   load_data             extended load result, held until the next load completes
//   mem_req/gnt           bus request and grant (address/write phase)
//   mem_addr/we/be/wdata  word address, write enable, byte enables, lane-replicated data
//   mem_rvalid/rdata      read response
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ls_valid,
    input  logic        ls_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        ls_done,
    output logic        ls_err,
    output logic [31:0] load_data,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t state;
    logic [CNT_W-1:0] cnt;
    logic [2:0] f3_q;
    logic [1:0] off_q;
    logic f3_ok, misaligned, dec_err, expire;
    logic [3:0] be_d;
    logic [31:0] wdata_d, shifted, ext;
    assign stall = ls_valid & ~ls_done;
    assign f3_ok = ls_we ? funct3 inside {3'b000, 3'b001, 3'b010}
                         : !(funct3 inside {3'b011, 3'b110, 3'b111});
    assign misaligned = (funct3[1:0] == 2'b01 & addr[0]) | (funct3[1:0] == 2'b10 & addr[1:0] != 2'b00);
    assign dec_err = ~f3_ok | misaligned;
    assign be_d = funct3[1:0] == 2'b00 ? 4'b0001 << addr[1:0]
                : funct3[1:0] == 2'b01 ? 4'b0011 << addr[1:0] : 4'b1111;
    assign wdata_d = funct3[1:0] == 2'b00 ? {4{store_data[7:0]}}
                   : funct3[1:0] == 2'b01 ? {2{store_data[15:0]}} : store_data;
    // Move the addressed byte/halfword to bit 0; funct3[2] selects zero extension.
    assign shifted = mem_rdata >> {off_q, 3'b000};
    assign ext = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & shifted[7]}}, shifted[7:0]}
               : f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & shifted[15]}}, shifted[15:0]} : shifted;
    assign expire = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            f3_q      <= '0;
            off_q     <= '0;
            ls_done   <= 1'b0;
            ls_err    <= 1'b0;
            load_data <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            ls_done <= 1'b0;
            ls_err  <= 1'b0;
            case (state)
                IDLE: if (ls_valid) begin
                    if (dec_err) begin
                        state     <= DONE;
                        ls_done   <= 1'b1;
                        ls_err    <= 1'b1;
                        load_data <= '0;
                    end else begin
                        state     <= REQ;
                        cnt       <= '0;
                        f3_q      <= funct3;
                        off_q     <= addr[1:0];
                        mem_req   <= 1'b1;
                        mem_addr  <= {addr[31:2], 2'b00};
                        mem_we    <= ls_we;
                        mem_be    <= be_d;
                        mem_wdata <= wdata_d;
                    end
                end
                // Progress beats expiry: grant/rvalid are checked before the timeout.
                REQ: if (mem_gnt) begin
                    mem_req <= 1'b0;
                    state   <= mem_we ? DONE : WAIT;
                    ls_done <= mem_we;
                end else if (expire) begin
                    mem_req   <= 1'b0;
                    state     <= DONE;
                    ls_done   <= 1'b1;
                    ls_err    <= 1'b1;
                    load_data <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                WAIT: if (mem_rvalid) begin
                    load_data <= ext;
                    state     <= DONE;
                    ls_done   <= 1'b1;
                end else if (expire) begin
                    state     <= DONE;
                    ls_done   <= 1'b1;
                    ls_err    <= 1'b1;
                    load_data <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized scoreboard bench for load_store_unit
module tb_load_store_unit;
    localparam int TO = 16;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic ls_valid = 1'b0, ls_we = 1'b0, mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [2:0] funct3 = '0;
    logic [31:0] addr = '0, store_data = '0, mem_rdata = '0;
    logic stall, ls_done, ls_err, mem_req, mem_we;
    logic [31:0] load_data, mem_addr, mem_wdata;
    logic [3:0] mem_be;
    typedef struct {
        logic        err;
        logic [31:0] ld;
        int          done_cyc;
        int          req_from;
        int          req_to;
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        we;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;
    int cyc_cnt = 0;
    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] drv_ld = '0;
    logic [31:0] last_ld = '0;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .ls_valid(ls_valid), .ls_we(ls_we), .funct3(funct3),
        .addr(addr), .store_data(store_data), .stall(stall), .ls_done(ls_done),
        .ls_err(ls_err), .load_data(load_data), .mem_req(mem_req), .mem_gnt(mem_gnt),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Reference model: size in bytes, alignment by modulo, extension by arithmetic.
    // g = cycles the grant is withheld, d = cycles from grant to rvalid.
    function automatic exp_t predict(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] sd, input int g, input int d,
                                     input logic [31:0] rd, input logic [31:0] prev, input int c0);
        exp_t e;
        int nb, off;
        logic legal;
        logic [63:0] v;
        nb = 1 << f3[1:0];
        off = int'(a[1:0]);
        legal = we ? (f3 <= 3'd2) : !(f3 == 3'd3 || f3 >= 3'd6);
        e.we = we;
        e.a = {a[31:2], 2'b00};
        e.be = '0;
        e.wd = '0;
        e.req_from = c0 + 1;
        if (!legal || (off % nb) != 0) begin
            e.err = 1'b1; e.ld = '0; e.done_cyc = c0 + 1; e.req_to = c0;
            return e;
        end
        e.be = 4'(((1 << nb) - 1) << off);
        for (int i = 0; i < 4; i++) e.wd[8*i +: 8] = sd[8*(i % nb) +: 8];
        if (g > TO - 1) begin
            e.err = 1'b1; e.ld = '0; e.req_to = c0 + TO; e.done_cyc = c0 + TO + 1;
        end else begin
            e.req_to = c0 + g + 1;
            if (we) begin
                e.err = 1'b0; e.ld = prev; e.done_cyc = c0 + g + 2;
            end else if (g + d - 1 <= TO - 1) begin
                v = 64'(rd) >> (8 * off);
                v = v & ((64'd1 << (8 * nb)) - 64'd1);
                if (!f3[2] && nb < 4 && v[8*nb-1]) v = v - (64'd1 << (8 * nb));
                e.err = 1'b0; e.ld = v[31:0]; e.done_cyc = c0 + g + d + 2;
            end else begin
                e.err = 1'b1; e.ld = '0; e.done_cyc = c0 + TO + 2;
            end
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", nm, act, exp, cyc_cnt);
        end
    endtask

    // Monitor: sole owner of the counters and of queue pops.
    initial begin
        forever begin
            @(negedge clk or posedge reset);
            if (reset) begin
                #1;
                chk("rst_req", 32'(mem_req), 0);
                chk("rst_done", 32'(ls_done), 0);
                chk("rst_err", 32'(ls_err), 0);
                chk("rst_load_data", load_data, 0);
                chk("rst_addr", mem_addr, 0);
                chk("rst_be", 32'(mem_be), 0);
                chk("rst_wdata", mem_wdata, 0);
                chk("rst_we", 32'(mem_we), 0);
                q.delete();
                last_ld = '0;
            end else begin
                chk("stall", 32'(stall), 32'(ls_valid & ~ls_done));
                if (q.size() == 0) begin
                    chk("idle_req", 32'(mem_req), 0);
                    chk("spurious_done", 32'(ls_done), 0);
                    chk("idle_err", 32'(ls_err), 0);
                    chk("idle_load_data", load_data, last_ld);
                end else begin
                    mon_e = q[0];
                    chk("req", 32'(mem_req), 32'(cyc_cnt >= mon_e.req_from && cyc_cnt <= mon_e.req_to));
                    if (mem_req) begin
                        chk("mem_addr", mem_addr, mon_e.a);
                        chk("mem_be", 32'(mem_be), 32'(mon_e.be));
                        chk("mem_wdata", mem_wdata, mon_e.wd);
                        chk("mem_we", 32'(mem_we), 32'(mon_e.we));
                    end
                    if (ls_done) begin
                        chk("done_cycle", 32'(cyc_cnt), 32'(mon_e.done_cyc));
                        chk("ls_err", 32'(ls_err), 32'(mon_e.err));
                        chk("load_data", load_data, mon_e.ld);
                        last_ld = mon_e.ld;
                        void'(q.pop_front());
                    end else begin
                        chk("busy_err", 32'(ls_err), 0);
                        chk("held_load_data", load_data, last_ld);
                        if (cyc_cnt >= mon_e.done_cyc) begin
                            chk("done_missing", 32'(ls_done), 1);
                            void'(q.pop_front());
                        end
                    end
                end
            end
        end
    end

    task automatic pulse_reset();
        #1 reset = 1'b1;
        ls_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        #6 reset = 1'b0;
        drv_ld = '0;
        @(posedge clk); #1;
    endtask

    // Called at posedge+1; that cycle is the accept cycle. Returns at posedge+1 of the
    // cycle after ls_done with ls_valid still high, so back-to-back issue is exercised.
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input int g, input int d,
                          input logic [31:0] rd, input int rst_at);
        exp_t e;
        bit fin;
        fin = 1'b0;
        e = predict(we, f3, a, sd, g, d, rd, drv_ld, cyc_cnt);
        drv_ld = e.ld;
        q.push_back(e);
        ls_valid = 1'b1; ls_we = we; funct3 = f3; addr = a; store_data = sd;
        mem_rdata = rd; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        for (int c = 1; c <= 40 && !fin; c++) begin
            @(posedge clk); #1;
            if (c == rst_at) begin
                pulse_reset();
                fin = 1'b1;
            end else if (ls_done) begin
                mem_gnt = 1'b0; mem_rvalid = 1'b0;
                fin = 1'b1;
                @(posedge clk); #1;
            end else begin
                mem_gnt = (c == g + 1);
                mem_rvalid = (c == g + 1 + d);
            end
        end
        if (!fin) pulse_reset();
    endtask

    initial begin
        logic [31:0] rd0;
        rd0 = 32'h80FF7F01;
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        run_op(0, 3'b000, 32'h103, 0, 0, 1, rd0, 0);
        run_op(0, 3'b100, 32'h102, 0, 0, 1, rd0, 0);
        run_op(0, 3'b001, 32'h102, 0, 0, 1, rd0, 0);
        run_op(0, 3'b010, 32'h100, 0, 0, 1, rd0, 0);
        run_op(1, 3'b000, 32'h205, 32'h123456AB, 0, 99, 0, 0);
        run_op(1, 3'b001, 32'h206, 32'h123456AB, 0, 99, 0, 0);
        run_op(0, 3'b010, 32'h102, 0, 0, 1, rd0, 0);
        run_op(1, 3'b001, 32'h301, 32'h11223344, 0, 99, 0, 0);
        run_op(0, 3'b011, 32'h100, 0, 0, 1, rd0, 0);
        run_op(0, 3'b010, 32'h400, 0, 5, 3, 32'hCAFEF00D, 0);
        run_op(0, 3'b010, 32'h500, 0, 99, 1, rd0, 0);
        run_op(0, 3'b001, 32'h602, 0, 0, TO, 32'h80010000, 0);
        run_op(0, 3'b101, 32'h602, 0, 0, TO + 1, 32'h80010000, 0);
        run_op(1, 3'b010, 32'h700, 32'hDEADBEEF, TO - 1, 99, 0, 0);
        run_op(1, 3'b010, 32'h700, 32'hDEADBEEF, TO, 99, 0, 0);
        run_op(0, 3'b010, 32'h800, 0, 0, 1, 32'h5A5AA5A5, 0);
        run_op(0, 3'b010, 32'h900, 0, 0, 99, rd0, 3);
        ls_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        @(posedge clk); #1 mem_rvalid = 1'b0;
        @(posedge clk); #1;
        run_op(0, 3'b010, 32'hA00, 0, 1, 2, 32'h0BADC0DE, 0);
        run_op(1, 3'b000, 32'hB01, 32'h000000EE, 99, 99, 0, 4);
        run_op(0, 3'b100, 32'hC03, 0, 0, 1, 32'hF1000000, 0);
        for (int n = 0; n < 200; n++) begin
            int g, d;
            if ($urandom_range(0, 3) == 0) begin
                ls_valid = 1'b0;
                mem_rvalid = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
                @(posedge clk); #1 mem_rvalid = 1'b0;
            end
            g = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 3);
            d = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 20) : $urandom_range(1, 4);
            run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                   g, d, $urandom, 0);
        end
        ls_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
